// File: rtl/spram_be_pkg.sv
// rtl/spram_be_pkg.sv - shared encodings for the byte-enable single-port RAM
package spram_be_pkg;

    localparam int WR_READ_FIRST  = 0;
    localparam int WR_WRITE_FIRST = 1;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/spram_be_parity.sv
// rtl/spram_be_parity.sv - per-byte even-parity generator
module spram_be_parity #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   data_i,
    output logic [DW/8-1:0] par_o
);

    always_comb begin
        par_o = '0;
        for (int i = 0; i < DW / 8; i++) begin
            par_o[i] = ^data_i[8*i +: 8];
        end
    end

endmodule

// File: rtl/spram_be.sv
// rtl/spram_be.sv - byte-enable single-port RAM with clear sweep after reset
// Optional per-byte parity storage and checking: define SPRAM_BE_PARITY_EN.
module spram_be
    import spram_be_pkg::*;
#(
    parameter int AW      = 10,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    parameter int WR_MODE = WR_READ_FIRST
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            we,
    input  logic [DW/8-1:0] be,
    input  logic            oe,
    input  logic [AW-1:0]   addr,
    input  logic [DW-1:0]   din,
    output logic [DW-1:0]   dout,
    output logic            dout_vld,
    output logic            busy,
    output logic            par_err
);

    localparam int NB    = DW / 8;
    localparam int DEPTH = 1 << AW;
`ifdef SPRAM_BE_PARITY_EN
    localparam int PW = DW + NB;
`else
    localparam int PW = DW;
`endif

    generate
        if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
            $error("spram_be: DW must be a non-zero multiple of 8");
        end
        if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_lat
            $error("spram_be: RD_LAT must be 1 or 2");
        end
    endgenerate

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            clr_we;
    logic            wr_en, rd_acc;
    logic [DW-1:0]   mem_q [DEPTH];
    logic [DW-1:0]   rd_old, rd_merged, rd_word;
    logic [PW-1:0]   rd_pl, fin_pl;
    logic            fin_vld;
    logic [DW-1:0]   dout_q;
    logic            dout_vld_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_we  = 1'b0;
        case (state_q)
            CLEAR: begin
                clr_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // rst is folded in so the port is gated in the very first reset cycle
    assign busy   = rst || (state_q == CLEAR);
    assign wr_en  = ce && we && !busy;
    assign rd_acc = ce && oe && !busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) mem_q[addr][8*i +: 8] <= din[8*i +: 8];
                end
            end
        end
    end

    assign rd_old = mem_q[addr];

    always_comb begin
        rd_merged = rd_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_en && be[i]) rd_merged[8*i +: 8] = din[8*i +: 8];
        end
    end

    assign rd_word = (WR_MODE == WR_WRITE_FIRST) ? rd_merged : rd_old;

`ifdef SPRAM_BE_PARITY_EN
    logic [NB-1:0] par_mem_q [DEPTH];
    logic [NB-1:0] wr_par, rd_par_old, rd_par_merged, chk_par;
    logic          par_err_q;

    spram_be_parity #(.DW(DW)) u_par_wr (.data_i(din), .par_o(wr_par));

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (clr_we) begin
                par_mem_q[cnt_q] <= '0;
            end else if (wr_en) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) par_mem_q[addr][i] <= wr_par[i];
                end
            end
        end
    end

    assign rd_par_old = par_mem_q[addr];

    always_comb begin
        rd_par_merged = rd_par_old;
        for (int i = 0; i < NB; i++) begin
            if (wr_en && be[i]) rd_par_merged[i] = wr_par[i];
        end
    end

    assign rd_pl = {(WR_MODE == WR_WRITE_FIRST) ? rd_par_merged : rd_par_old, rd_word};

    spram_be_parity #(.DW(DW)) u_par_chk (.data_i(fin_pl[DW-1:0]), .par_o(chk_par));

    always_ff @(posedge clk) begin
        if (rst) par_err_q <= 1'b0;
        else     par_err_q <= fin_vld && (chk_par != fin_pl[PW-1:DW]);
    end

    assign par_err = par_err_q;
`else
    assign rd_pl   = rd_word;
    assign par_err = 1'b0;
`endif

    // Read payload (data plus any stored parity) travels as one word
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s1_vld_q;
            logic [PW-1:0] s1_pl_q;

            always_ff @(posedge clk) begin
                if (rst) s1_vld_q <= 1'b0;
                else     s1_vld_q <= rd_acc;
            end

            always_ff @(posedge clk) begin
                if (rd_acc) s1_pl_q <= rd_pl;
            end

            assign fin_vld = s1_vld_q;
            assign fin_pl  = s1_pl_q;
        end else begin : g_lat1
            assign fin_vld = rd_acc;
            assign fin_pl  = rd_pl;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q     <= '0;
            dout_vld_q <= 1'b0;
        end else begin
            dout_vld_q <= fin_vld;
            if (fin_vld) dout_q <= fin_pl[DW-1:0];
        end
    end

    assign dout     = dout_q;
    assign dout_vld = dout_vld_q;

endmodule

// File: tb/tb_spram_be.sv
// tb/tb_spram_be.sv - scoreboard bench for spram_be (AW=4, RD_LAT=2)
module tb_spram_be;
    import spram_be_pkg::*;

    localparam int AW      = 4;
    localparam int DW      = 32;
    localparam int NB      = DW / 8;
    localparam int DEPTH   = 1 << AW;
    localparam int RD_LAT  = 2;
    localparam int WR_MODE = WR_READ_FIRST;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            ce = 1'b0, we = 1'b0, oe = 1'b0;
    logic [NB-1:0]   be = '0;
    logic [AW-1:0]   addr = '0;
    logic [DW-1:0]   din = '0;
    logic [DW-1:0]   dout;
    logic            dout_vld, busy, par_err;

    spram_be #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .WR_MODE(WR_MODE)) dut (
        .clk(clk), .rst(rst), .ce(ce), .we(we), .be(be), .oe(oe),
        .addr(addr), .din(din), .dout(dout), .dout_vld(dout_vld),
        .busy(busy), .par_err(par_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          perr;
        int unsigned   cyc;
    } exp_t;

    exp_t          sb[$];
    exp_t          e;
    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_dout = '0;
    int unsigned   cyc = 0;
    int            tests = 0;
    int            fails = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Drives one cycle of stimulus; live ops update the model, push ops queue a result
    task automatic op(input bit w, input bit r, input logic [NB-1:0] b, input int a,
                      input logic [DW-1:0] d, input bit live, input bit push, input bit perr);
        logic [DW-1:0] old, merged;
        logic [AW-1:0] ad;
        ad = AW'(a);
        ce = w || r; we = w; oe = r; be = b; addr = ad; din = d;
        if (live) begin
            old    = model[ad];
            merged = old;
            if (w) begin
                for (int i = 0; i < NB; i++)
                    if (b[i]) merged[8*i +: 8] = d[8*i +: 8];
            end
            if (r && push)
                sb.push_back(exp_t'{data: (WR_MODE == WR_WRITE_FIRST) ? merged : old,
                                    perr: perr, cyc: cyc + RD_LAT});
            if (w) model[ad] = merged;
        end
        @(posedge clk); #2;
        ce = 1'b0; we = 1'b0; oe = 1'b0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_busy(output int n);
        n = 0;
        #1;
        while (busy && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        #1;
        check("clear_timeout", 64'(n < 40), 64'(1));
    endtask

    task automatic do_reset(input int n_cyc);
        int n;
        rst = 1'b1;
        tick(n_cyc);
        check("rst_busy", 64'(busy), 64'(1));
        check("rst_dout", 64'(dout), 64'(0));
        check("rst_vld", 64'(dout_vld), 64'(0));
        check("rst_par", 64'(par_err), 64'(0));
        rst = 1'b0;
        wait_busy(n);
        check("clear_cycles", 64'(n), 64'(DEPTH));
        foreach (model[i]) model[i] = '0;
    endtask

    always @(negedge clk) begin
        if (dout_vld) begin
            if (sb.size() == 0) begin
                check("spurious_vld", 64'(dout_vld), 64'(0));
            end else begin
                e = sb.pop_front();
                check("dout", 64'(dout), 64'(e.data));
                check("latency", 64'(cyc), 64'(e.cyc));
                check("par_err", 64'(par_err), 64'(e.perr));
                last_dout = e.data;
            end
        end else if (rst) begin
            last_dout = '0;
        end else begin
            check("dout_hold", 64'(dout), 64'(last_dout));
            check("par_idle", 64'(par_err), 64'(0));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        bit w, r;
        int a;
        foreach (model[i]) model[i] = '0;
        #2;

        do_reset(3);
        for (int i = 0; i < DEPTH; i++) op(0, 1, '0, i, '0, 1, 1, 0);
        tick(RD_LAT + 3);

        op(1, 0, 4'hF, 5, 32'hAABBCCDD, 1, 1, 0);
        op(1, 0, 4'b0101, 5, 32'h11223344, 1, 1, 0);
        op(0, 1, '0, 5, '0, 1, 1, 0);
        tick(RD_LAT + 3);

        op(1, 0, 4'hF, 1, 32'h01010101, 1, 1, 0);
        op(1, 0, 4'hF, 2, 32'h02020202, 1, 1, 0);
        op(1, 0, 4'hF, 3, 32'h03030303, 1, 1, 0);
        for (int i = 1; i <= 3; i++) op(0, 1, '0, i, '0, 1, 1, 0);
        tick(RD_LAT + 4);

        op(1, 0, 4'hF, 7, 32'h0, 1, 1, 0);
        op(1, 1, 4'hF, 7, 32'hFFFFFFFF, 1, 1, 0);
        op(0, 1, '0, 7, '0, 1, 1, 0);
        tick(RD_LAT + 3);

        for (int k = 0; k < 60; k++) begin
            a = $urandom_range(DEPTH - 1);
            w = 1'($urandom_range(1));
            r = 1'($urandom_range(1));
            op(w, r, NB'($urandom), a, $urandom, 1, 1, 0);
        end
        tick(RD_LAT + 3);

`ifdef SPRAM_BE_PARITY_EN
        op(1, 0, 4'hF, 3, 32'h12345678, 1, 1, 0);
        dut.par_mem_q[3] = dut.par_mem_q[3] ^ 4'b0001;
        op(0, 1, '0, 3, '0, 1, 1, 1);
        tick(RD_LAT + 3);
`endif

        // read in flight when rst rises must be dropped
        op(0, 1, '0, 5, '0, 1, 0, 0);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        foreach (model[i]) model[i] = '0;
        tick(4);
        op(1, 0, 4'hF, 1, 32'hDEADBEEF, 0, 0, 0);
        op(0, 1, '0, 2, '0, 0, 0, 0);
        wait_busy(n);
        op(0, 1, '0, 1, '0, 1, 1, 0);
        tick(RD_LAT + 3);

        // mid-clear reset restarts the sweep from address 0
        op(1, 0, 4'hF, 9, 32'hCAFEF00D, 1, 1, 0);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(5);
        do_reset(1);
        for (int i = 0; i < DEPTH; i++) op(0, 1, '0, i, '0, 1, 1, 0);
        tick(RD_LAT + 3);

        check("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spram_be.md
SPRAM_BE -- requirements
Module: spram_be

Interface
REQ-001 SHALL have parameter AW, default 10, address bits (depth 2^AW words).
REQ-002 SHALL have parameter DW, default 32, data bits, legal only as a multiple of 8.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles, legal values 1 or 2.
REQ-004 SHALL have parameter WR_MODE, default 0, read-during-write result: 0 = read-first (old data), 1 = write-first (new merged data).
REQ-005 SHALL have one clock and a synchronous, active-high reset:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
REQ-006 SHALL have the remaining ports:
- ce  in  1  chip enable
- we  in  1  write enable
- be  in  DW/8  byte write enables
- oe  in  1  read request
- addr  in  AW  word address
- din  in  DW  write data
- dout  out  DW  read data
- dout_vld  out  1  read-data valid pulse
- busy  out  1  clear engine active
- par_err  out  1  parity error pulse

Function
REQ-007 SHALL write byte i of din into mem[addr] on a rising edge where ce&&we&&be[i]&&!busy; bytes with be[i]=0 SHALL be unchanged.
REQ-008 SHALL accept a read on a rising edge where ce&&oe&&!busy, and present the data on dout with dout_vld=1 exactly RD_LAT cycles later, for one cycle per accepted read.
REQ-009 SHALL pipeline back-to-back reads at one per cycle with no bubbles.
REQ-010 SHALL hold dout at the last read value when no read completes; dout SHALL change only on a completing read.
REQ-011 SHALL, for a simultaneous read and write to the same address, return pre-write data (WR_MODE=0) or byte-merged post-write data (WR_MODE=1).
REQ-012 SHALL implement a two-state machine, CLEAR and IDLE:
- CLEAR writes zero to one address per cycle, starting at 0, with busy=1.
- CLEAR moves to IDLE on the cycle after address 2^AW-1 is written.
- Total clear time is exactly 2^AW cycles after rst falls.
REQ-013 SHALL ignore ce/we/oe while busy=1: no write, no read accepted, no dout_vld.
REQ-014 SHALL let reads already in the pipeline when rst rises be discarded, with no dout_vld.

Reset
REQ-015 SHALL, while rst=1, hold state=CLEAR, clear counter=0, busy=1, dout=0, dout_vld=0, par_err=0, and flush the read pipeline.
REQ-016 SHALL restart the clear sweep from address 0 when rst is asserted during CLEAR or IDLE.

Configuration
REQ-017 SHALL, with SPRAM_BE_PARITY_EN defined, store one even-parity bit per byte:
- Update the bit for each written byte; clear writes parity 0.
- Check on read; pulse par_err with dout_vld when any byte mismatches.
REQ-018 SHALL, without SPRAM_BE_PARITY_EN, add no parity storage or logic and tie par_err to 0.

Structure
REQ-019 SHALL place the WR_MODE encodings (WR_READ_FIRST=0, WR_WRITE_FIRST=1) and the state enum (CLEAR, IDLE) in package spram_be_pkg.
REQ-020 SHALL implement per-byte parity generation in sub-module spram_be_parity (DW in, DW/8 parity out), instantiated for write and for check.
REQ-021 SHALL flag illegal DW or RD_LAT at elaboration.

Verification
REQ-022 SHALL cover clear after reset: AW=4, rst for 3 cycles, then read addresses 0..15 -> busy high exactly 16 cycles; all reads return 0; par_err=0.
REQ-023 SHALL cover byte enables: write 0xAABBCCDD to addr 5, then din=0x11223344 with be=0b0101 -> read returns 0xAA22CC44.
REQ-024 SHALL cover latency and streaming with RD_LAT=2: reads of addrs 1,2,3 in consecutive cycles -> dout_vld high on cycles +2,+3,+4 with the matching data; dout held afterwards.
REQ-025 SHALL cover read-during-write: mem[7]=0x0 and same-cycle write 0xFFFFFFFF with read addr 7 -> returns 0x0 (WR_MODE=0) or 0xFFFFFFFF (WR_MODE=1).
REQ-026 SHALL cover busy gating and mid-operation reset: write issued while busy=1 -> memory unchanged; rst pulsed mid-clear or with a read in flight -> no dout_vld, sweep restarts at 0.
REQ-027 SHALL cover parity, with SPRAM_BE_PARITY_EN: force-flip a stored bit of addr 3 -> read pulses par_err with dout_vld; without the macro par_err stays 0.
